// File: rtl/axi4_mm2s_reader.sv
// Command (addr, beats) -> AXI4 INCR read bursts, one outstanding; R data forwarded as AXI4-Stream.
// Zero-latency R->stream pass-through; RREADY follows TREADY, so the stream sink backpressures the slave.
module axi4_mm2s_reader #(
    parameter int C_M_AXI_BURST_LEN    = 16,
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXI_ARUSER_WIDTH = 1,
    parameter int C_CMD_BEATS_WIDTH    = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [C_CMD_BEATS_WIDTH-1:0]    CMD_BEATS,
    input  logic                            CMD_VALID,
    output logic                            CMD_READY,
    output logic                            DONE,
    output logic                            ERR,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_ARUSER,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_RUSER,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY
);
    localparam int AW       = C_M_AXI_ADDR_WIDTH;
    localparam int BW       = C_CMD_BEATS_WIDTH;
    localparam int SIZE_LOG = $clog2(C_M_AXI_DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   remaining;
    logic [7:0]      beat_cnt;
    logic [7:0]      arlen_q;
    logic            err;
    logic            r_hs;
    logic            last_beat;
    logic            rem_zero;
    logic            unused_ok;

    // ARLEN for the next burst: min(beats, BURST_LEN) - 1
    function automatic logic [7:0] burst_len(input logic [BW-1:0] beats);
        if (beats >= BW'(C_M_AXI_BURST_LEN))
            return 8'(C_M_AXI_BURST_LEN - 1);
        else
            return 8'(beats - BW'(1));
    endfunction

    assign last_beat = (beat_cnt == 8'd0);
    assign rem_zero  = (remaining == '0);
    assign r_hs      = (state == DATA) && M_AXI_RVALID && M_AXIS_TREADY;
    assign unused_ok = ^{M_AXI_RID, M_AXI_RUSER};

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            arlen_q   <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (CMD_VALID) begin
                    addr      <= CMD_ADDR;
                    remaining <= CMD_BEATS;
                    arlen_q   <= burst_len(CMD_BEATS);
                    err       <= 1'b0;
                end
                ADDR: if (M_AXI_ARREADY) begin
                    beat_cnt  <= arlen_q;
                    addr      <= addr + ((AW'(arlen_q) + AW'(1)) << SIZE_LOG);
                    remaining <= remaining - (BW'(arlen_q) + BW'(1));
                end
                DATA: if (r_hs) begin
                    beat_cnt <= beat_cnt - 8'd1;
                    // Beat count is authoritative; a bad response or misplaced RLAST only flags
                    if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != last_beat))
                        err <= 1'b1;
                    if (last_beat)
                        arlen_q <= burst_len(remaining);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (CMD_VALID) state_nxt = (CMD_BEATS == '0) ? FIN : ADDR;
            ADDR: if (M_AXI_ARREADY) state_nxt = DATA;
            DATA: if (r_hs && last_beat) state_nxt = rem_zero ? FIN : ADDR;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign CMD_READY     = (state == IDLE);
    assign DONE          = (state == FIN);
    assign ERR           = err;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = '0;
    assign M_AXI_ARVALID = (state == ADDR);

    assign M_AXI_RREADY  = (state == DATA) && M_AXIS_TREADY;
    assign M_AXIS_TDATA  = M_AXI_RDATA;
    assign M_AXIS_TVALID = (state == DATA) && M_AXI_RVALID;
    assign M_AXIS_TLAST  = (state == DATA) && last_beat && rem_zero;
endmodule

// File: tb/tb_axi4_mm2s_reader.sv
// Directed bench for axi4_mm2s_reader: behavioural AXI read slave (RDATA = beat byte address) and stream monitor.
module tb_axi4_mm2s_reader;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] cmd_addr, cmd_beats;
    logic        cmd_valid, cmd_ready, done, err;
    logic [0:0]  arid, aruser, rid, ruser;
    logic [31:0] araddr, rdata, tdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, rresp;
    logic        arlock, arvalid, arready;
    logic [3:0]  arcache, arqos;
    logic        rlast, rvalid, rready, tlast, tvalid, tready;

    assign rid   = 1'b0;
    assign ruser = 1'b0;

    axi4_mm2s_reader dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .CMD_ADDR(cmd_addr), .CMD_BEATS(cmd_beats), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .DONE(done), .ERR(err),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
        .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready)
    );

    int n_pass = 0, n_total = 0;

    // Slave knobs, written only by the stimulus process
    int          ar_delay = 0;
    int          err_g    = -1;
    int          early_g  = -1;
    logic [31:0] cmd_base = 32'h0;
    bit          tog      = 1'b0;
    logic        tog_phase = 1'b0;

    always @(negedge clk) tog_phase <= ~tog_phase;
    assign tready = tog ? tog_phase : 1'b1;

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (err_g >= 0 && int'((a - cmd_base) >> 2) == err_g) ? 2'b10 : 2'b00;
    endfunction
    function automatic logic last_of(input logic [31:0] a, input int idx, input int len);
        return (idx == len) || (early_g >= 0 && int'((a - cmd_base) >> 2) == early_g);
    endfunction

    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    bit          s_busy;
    logic [31:0] s_addr;
    int          s_idx, s_len, ar_wait;

    always @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; rdata <= '0;
            s_busy <= 1'b0; ar_wait <= 0;
        end else if (!s_busy) begin
            if (arvalid && arready) begin
                ar_addr_q.push_back(araddr);
                ar_len_q.push_back(arlen);
                arready <= 1'b0; ar_wait <= 0; s_busy <= 1'b1;
                s_addr <= araddr; s_len <= int'(arlen); s_idx <= 0;
                rvalid <= 1'b1; rdata <= araddr;
                rresp <= resp_of(araddr); rlast <= last_of(araddr, 0, int'(arlen));
            end else if (arvalid) begin
                if (ar_wait >= ar_delay) arready <= 1'b1;
                else ar_wait <= ar_wait + 1;
            end
        end else if (rvalid && rready) begin
            if (s_idx == s_len) begin
                s_busy <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00;
            end else begin
                s_idx <= s_idx + 1;
                rdata <= s_addr + 32'(4 * (s_idx + 1));
                rresp <= resp_of(s_addr + 32'(4 * (s_idx + 1)));
                rlast <= last_of(s_addr + 32'(4 * (s_idx + 1)), s_idx + 1, s_len);
            end
        end
    end

    logic [31:0] td_q[$];
    logic        tl_q[$];
    int          cyc = 0, last_beat_cyc = 0, done_cnt = 0, unstable = 0, stall_cyc = 0, mirror_bad = 0;
    bit          hold = 1'b0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            hold <= 1'b0;
        end else begin
            if (hold && (!arvalid || araddr != hold_addr || arlen != hold_len)) unstable <= unstable + 1;
            hold <= arvalid && !arready; hold_addr <= araddr; hold_len <= arlen;
            if (arvalid && !arready) stall_cyc <= stall_cyc + 1;
            if (tvalid && (rready !== tready)) mirror_bad <= mirror_bad + 1;
            if (tvalid && tready) begin
                td_q.push_back(tdata); tl_q.push_back(tlast); last_beat_cyc <= cyc;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int acc_cyc, done_cyc;

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        cmd_addr = a; cmd_beats = b; cmd_valid = 1'b1; cmd_base = a;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        n_total++;
        if (!cmd_ready) $display("FAIL cmd_accept: CMD_READY stayed %b, required 1", cmd_ready);
        else n_pass++;
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin @(negedge clk); n++; end
        done_cyc = cyc;
        n_total++;
        if (!done) $display("FAIL done_seen: DONE=%b after %0d cycles, required 1", done, n);
        else n_pass++;
    endtask

    task automatic scan(input int sb, input logic [31:0] a, input int exp_n,
                        output int n, output int bad_d, output int bad_l);
        n = td_q.size() - sb; bad_d = 0; bad_l = 0;
        for (int i = 0; i < n; i++) begin
            if (td_q[sb+i] !== a + 32'(4 * i)) bad_d++;
            if (tl_q[sb+i] !== (i == exp_n - 1)) bad_l++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({cmd_ready, arvalid, rready, tvalid, done, err} !== 6'b100000)
            $display("FAIL reset_outputs: rdy/arv/rrdy/tv/done/err=%b, required 100000",
                     {cmd_ready, arvalid, rready, tvalid, done, err});
        else n_pass++;
        n_total++;
        if ({arsize, arburst, arcache, arid, arlock, arprot, arqos, aruser} !== {3'd2, 2'b01, 4'b0011, 10'd0})
            $display("FAIL ar_constants: size=%0d burst=%0d cache=%0d id=%0d lock=%0d prot=%0d qos=%0d user=%0d",
                     arsize, arburst, arcache, arid, arlock, arprot, arqos, aruser);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_bursts();
        int ab = ar_addr_q.size(), sb = td_q.size(), d0 = done_cnt, n, bd, bl;
        issue(32'h1000, 32'd32);
        wait_done();
        scan(sb, 32'h1000, 32, n, bd, bl);
        n_total++; if (ar_addr_q.size() - ab !== 2) $display("FAIL tb_ar_count: got %0d, required 2", ar_addr_q.size() - ab); else n_pass++;
        n_total++; if ({ar_addr_q[ab], ar_len_q[ab]} !== {32'h1000, 8'd15}) $display("FAIL tb_ar0: addr=%h len=%0d, required 1000/15", ar_addr_q[ab], ar_len_q[ab]); else n_pass++;
        n_total++; if ({ar_addr_q[ab+1], ar_len_q[ab+1]} !== {32'h1040, 8'd15}) $display("FAIL tb_ar1: addr=%h len=%0d, required 1040/15", ar_addr_q[ab+1], ar_len_q[ab+1]); else n_pass++;
        n_total++; if (n !== 32) $display("FAIL tb_beats: got %0d, required 32", n); else n_pass++;
        n_total++; if (bd !== 0) $display("FAIL tb_data: %0d bad beats, required 0", bd); else n_pass++;
        n_total++; if (bl !== 0) $display("FAIL tb_tlast: %0d misplaced TLAST, required 0", bl); else n_pass++;
        n_total++; if (done_cyc - last_beat_cyc !== 1) $display("FAIL tb_done_lat: got %0d, required 1", done_cyc - last_beat_cyc); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (done_cnt - d0 !== 1 || done !== 1'b0) $display("FAIL tb_done_pulse: pulses=%0d done=%b, required 1/0", done_cnt - d0, done); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL tb_err: got %b, required 0", err); else n_pass++;
    endtask

    task automatic test_partial();
        int ab = ar_addr_q.size(), sb = td_q.size(), n, bd, bl;
        issue(32'h1000, 32'd20);
        wait_done();
        scan(sb, 32'h1000, 20, n, bd, bl);
        n_total++; if (ar_addr_q.size() - ab !== 2) $display("FAIL pt_ar_count: got %0d, required 2", ar_addr_q.size() - ab); else n_pass++;
        n_total++; if ({ar_len_q[ab], ar_addr_q[ab+1], ar_len_q[ab+1]} !== {8'd15, 32'h1040, 8'd3}) $display("FAIL pt_ar: len0=%0d addr1=%h len1=%0d, required 15/1040/3", ar_len_q[ab], ar_addr_q[ab+1], ar_len_q[ab+1]); else n_pass++;
        n_total++; if (n !== 20 || bd !== 0 || bl !== 0) $display("FAIL pt_stream: beats=%0d bad_data=%0d bad_last=%0d, required 20/0/0", n, bd, bl); else n_pass++;
    endtask

    task automatic test_zero_beats();
        int ab = ar_addr_q.size(), sb = td_q.size();
        issue(32'h3000, 32'd0);
        wait_done();
        n_total++; if (done_cyc - acc_cyc !== 1) $display("FAIL zb_done_lat: got %0d, required 1", done_cyc - acc_cyc); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (ar_addr_q.size() - ab !== 0 || td_q.size() - sb !== 0) $display("FAIL zb_no_traffic: ars=%0d beats=%0d, required 0/0", ar_addr_q.size() - ab, td_q.size() - sb); else n_pass++;
        n_total++; if (err !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL zb_state: err=%b rdy=%b, required 0/1", err, cmd_ready); else n_pass++;
    endtask

    task automatic test_stall();
        int ab = ar_addr_q.size(), sb = td_q.size(), u0 = unstable, s0 = stall_cyc, m0 = mirror_bad, n, bd, bl;
        ar_delay = 5; tog = 1'b1;
        issue(32'h2000, 32'd20);
        wait_done();
        ar_delay = 0; tog = 1'b0;
        scan(sb, 32'h2000, 20, n, bd, bl);
        n_total++; if (stall_cyc - s0 < 10) $display("FAIL st_stalled: %0d stall cycles, required >=10", stall_cyc - s0); else n_pass++;
        n_total++; if (unstable - u0 !== 0) $display("FAIL st_ar_stable: %0d changes while stalled, required 0", unstable - u0); else n_pass++;
        n_total++; if (mirror_bad - m0 !== 0) $display("FAIL st_rready_mirror: %0d mismatched cycles, required 0", mirror_bad - m0); else n_pass++;
        n_total++; if ({ar_addr_q[ab], ar_len_q[ab], ar_addr_q[ab+1], ar_len_q[ab+1]} !== {32'h2000, 8'd15, 32'h2040, 8'd3}) $display("FAIL st_ar: %h/%0d %h/%0d, required 2000/15 2040/3", ar_addr_q[ab], ar_len_q[ab], ar_addr_q[ab+1], ar_len_q[ab+1]); else n_pass++;
        n_total++; if (n !== 20 || bd !== 0 || bl !== 0) $display("FAIL st_stream: beats=%0d bad_data=%0d bad_last=%0d, required 20/0/0", n, bd, bl); else n_pass++;
    endtask

    task automatic test_errors();
        int sb = td_q.size();
        err_g = 2;
        issue(32'h1000, 32'd20);
        wait_done();
        err_g = -1;
        n_total++; if (err !== 1'b1 || td_q.size() - sb !== 20) $display("FAIL er_rresp: err=%b beats=%0d, required 1/20", err, td_q.size() - sb); else n_pass++;
        early_g = 5; sb = td_q.size();
        issue(32'h1000, 32'd16);
        n_total++; if (err !== 1'b0) $display("FAIL er_clear1: err=%b, required 0", err); else n_pass++;
        wait_done();
        early_g = -1;
        n_total++; if (err !== 1'b1 || td_q.size() - sb !== 16) $display("FAIL er_rlast: err=%b beats=%0d, required 1/16", err, td_q.size() - sb); else n_pass++;
        issue(32'h1000, 32'd4);
        n_total++; if (err !== 1'b0) $display("FAIL er_clear2: err=%b, required 0", err); else n_pass++;
        wait_done();
        n_total++; if (err !== 1'b0) $display("FAIL er_clean_run: err=%b, required 0", err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ab, sb = td_q.size(), n = 0, bd, bl;
        err_g = 1;
        issue(32'h1000, 32'd32);
        while (td_q.size() - sb < 4 && n < 200) begin @(negedge clk); n++; end
        err_g = -1;
        n_total++; if (err !== 1'b1 || td_q.size() - sb !== 4) $display("FAIL rm_pre: err=%b beats=%0d, required 1/4", err, td_q.size() - sb); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if ({cmd_ready, tvalid, rready, arvalid, err} !== 5'b10000) $display("FAIL rm_idle: rdy/tv/rrdy/arv/err=%b, required 10000", {cmd_ready, tvalid, rready, arvalid, err}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        ab = ar_addr_q.size(); sb = td_q.size();
        issue(32'h5000, 32'd4);
        wait_done();
        scan(sb, 32'h5000, 4, n, bd, bl);
        n_total++; if (ar_addr_q.size() - ab !== 1 || {ar_addr_q[ab], ar_len_q[ab]} !== {32'h5000, 8'd3}) $display("FAIL rm_ar: count=%0d addr=%h len=%0d, required 1/5000/3", ar_addr_q.size() - ab, ar_addr_q[ab], ar_len_q[ab]); else n_pass++;
        n_total++; if (n !== 4 || bd !== 0 || bl !== 0 || err !== 1'b0) $display("FAIL rm_stream: beats=%0d bad_data=%0d bad_last=%0d err=%b, required 4/0/0/0", n, bd, bl, err); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        test_reset();
        test_two_bursts();
        test_partial();
        test_zero_beats();
        test_stall();
        test_errors();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
